// File: rtl/sdram_burst_sched_pkg.sv
// Shared encodings for the SDRAM burst scheduler: request opcodes, scheduler
// FSM states and the command-engine state numbering the scheduler hands off to.
package sdram_burst_sched_pkg;

    localparam logic [1:0] OP_WR  = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;
    localparam logic [1:0] OP_REF = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } sched_state_t;

    // Command-engine states; the engine owns these, the scheduler only waits for done.
    localparam logic [3:0] W_IDLE  = 4'd0;
    localparam logic [3:0] W_ACT   = 4'd1;
    localparam logic [3:0] W_TRCD  = 4'd2;
    localparam logic [3:0] W_WRITE = 4'd3;
    localparam logic [3:0] W_READ  = 4'd4;
    localparam logic [3:0] W_CL    = 4'd5;
    localparam logic [3:0] W_REF   = 4'd6;
    localparam logic [3:0] W_TRFC  = 4'd7;
    localparam logic [3:0] W_TRP   = 4'd8;

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running auto-refresh timer: raises a pending refresh at every wrap and
// flags (stickily) a wrap that lands while the previous refresh is still pending.
module sdram_ref_timer #(
    parameter int REF_PERIOD = 1037
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_grant,
    output logic ref_pend,
    output logic ref_miss
);

    localparam int CNT_W = $clog2(REF_PERIOD);

    logic [CNT_W-1:0] cnt;
    logic             pend_q;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(REF_PERIOD - 1));
    // The wrap cycle itself already counts as pending so the scheduler can
    // issue the refresh on the very edge the flag is registered.
    assign ref_pend = pend_q | wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pend_q   <= 1'b0;
            ref_miss <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) begin
                pend_q <= 1'b1;
                if (pend_q && !ref_grant) ref_miss <= 1'b1;
            end else if (ref_grant) begin
                pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_burst_sched.sv
// Arbitrates camera write bursts, display read bursts and auto-refresh onto the
// single SDRAM command engine, and keeps the double-buffered frame address map.
module sdram_burst_sched
    import sdram_burst_sched_pkg::*;
#(
    parameter int BURST_LEN   = 256,
    parameter int WR_THRESH   = 256,
    parameter int RD_THRESH   = 1024,
    parameter int RD_URGENT   = 256,
    parameter int REF_PERIOD  = 1037,
    parameter int FRAME_WORDS = 480000,
    parameter int ADDR_W      = 22
) (
    input  logic              clk_133M_i,
    input  logic              rst_133i,
    input  logic              sched_en_i,
    input  logic [10:0]       wr_fifo_used_i,
    input  logic [10:0]       rd_fifo_used_i,
    output logic              burst_req_o,
    output logic [1:0]        burst_op_o,
    output logic [ADDR_W-1:0] burst_addr_o,
    input  logic              burst_ack_i,
    input  logic              burst_done_i,
    output logic              wr_buf_o,
    output logic              rd_buf_o,
    output logic              ref_miss_o,
    output sched_state_t      sched_state_o
);

    localparam int OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] BURST_STEP = OFF_W'(BURST_LEN);

    sched_state_t      state_q, state_d;
    logic              ref_pend, ref_grant;
    logic [OFF_W-1:0]  wr_off, rd_off;
    logic              frame_rdy;
    logic              rd_urgent, wr_elig, rd_elig;
    logic              issue, done_now;
    logic [1:0]        issue_op;
    logic [ADDR_W-1:0] issue_addr;
    logic              wr_wrap, rd_wrap, wr_buf_nx;

    // Handshake: burst_req_o is a valid that stays high with op/addr frozen
    // until the single-cycle burst_ack_i; burst_done_i marks end of that burst.
    assign ref_grant = (state_q == S_REQ) && burst_ack_i && (burst_op_o == OP_REF);

    sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref_timer (
        .clk       (clk_133M_i),
        .rst_n     (rst_133i),
        .ref_grant (ref_grant),
        .ref_pend  (ref_pend),
        .ref_miss  (ref_miss_o)
    );

    assign rd_urgent = 32'(rd_fifo_used_i) < 32'(RD_URGENT);
    assign wr_elig   = 32'(wr_fifo_used_i) >= 32'(WR_THRESH);
    assign rd_elig   = 32'(rd_fifo_used_i) < 32'(RD_THRESH);

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_op   = OP_WR;
        issue_addr = '0;
        done_now   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ref_pend) begin
                    issue    = 1'b1;
                    issue_op = OP_REF;
                end else if (sched_en_i && rd_urgent) begin
                    issue      = 1'b1;
                    issue_op   = OP_RD;
                    issue_addr = {rd_buf_o, rd_off};
                end else if (sched_en_i && wr_elig) begin
                    issue      = 1'b1;
                    issue_op   = OP_WR;
                    issue_addr = {wr_buf_o, wr_off};
                end else if (sched_en_i && rd_elig) begin
                    issue      = 1'b1;
                    issue_op   = OP_RD;
                    issue_addr = {rd_buf_o, rd_off};
                end
                if (issue) state_d = S_REQ;
            end
            S_REQ: begin
                if (burst_ack_i) begin
                    done_now = burst_done_i;
                    state_d  = burst_done_i ? S_IDLE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (burst_done_i) begin
                    done_now = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_wrap = done_now && (burst_op_o == OP_WR) &&
                     (32'(wr_off) + 32'(BURST_LEN) == 32'(FRAME_WORDS));
    assign rd_wrap = done_now && (burst_op_o == OP_RD) &&
                     (32'(rd_off) + 32'(BURST_LEN) == 32'(FRAME_WORDS));
    // Reader flips to the buffer the writer has just left, using the post-wrap writer buffer.
    assign wr_buf_nx = wr_wrap ? ~wr_buf_o : wr_buf_o;

    always_ff @(posedge clk_133M_i or negedge rst_133i) begin
        if (!rst_133i) begin
            state_q      <= S_IDLE;
            burst_req_o  <= 1'b0;
            burst_op_o   <= OP_WR;
            burst_addr_o <= '0;
            wr_off       <= '0;
            rd_off       <= '0;
            wr_buf_o     <= 1'b0;
            rd_buf_o     <= 1'b1;
            frame_rdy    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                burst_req_o  <= 1'b1;
                burst_op_o   <= issue_op;
                burst_addr_o <= issue_addr;
            end else if ((state_q == S_REQ) && burst_ack_i) begin
                burst_req_o <= 1'b0;
            end
            if (done_now && (burst_op_o == OP_WR)) wr_off <= wr_wrap ? '0 : wr_off + BURST_STEP;
            if (done_now && (burst_op_o == OP_RD)) rd_off <= rd_wrap ? '0 : rd_off + BURST_STEP;
            wr_buf_o <= wr_buf_nx;
            if (rd_wrap && (frame_rdy || wr_wrap)) begin
                rd_buf_o  <= ~wr_buf_nx;
                frame_rdy <= 1'b0;
            end else if (wr_wrap) begin
                frame_rdy <= 1'b1;
            end
        end
    end

    assign sched_state_o = state_q;

endmodule
